// File: rtl/cache_bank_sram.sv
// Multi-port SRAM bank: zero-initialising sweep after reset, byte-masked writes, two-stage reads.
// Optional build macro CACHE_BANK_SRAM_FWD_EN merges same-cycle writes into colliding reads.
module cache_bank_sram #(
  parameter  int NUM_PORTS  = 2,
  parameter  int DATA_WIDTH = 32,
  parameter  int WORDS      = 256,
  localparam int IDX_W      = $clog2(WORDS),
  localparam int NB         = DATA_WIDTH / 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_PORTS-1:0]                  IN_ce,
  input  logic [NUM_PORTS-1:0]                  IN_we,
  input  logic [NUM_PORTS-1:0][NB-1:0]          IN_wm,
  input  logic [NUM_PORTS-1:0][IDX_W-1:0]       IN_addr,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  IN_data,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  OUT_data,
  output logic                                  OUT_busy
);

  typedef enum logic {INIT, READY} state_t;

  state_t                                 state_q, state_d;
  logic [IDX_W-1:0]                       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]                  mem [WORDS];
  logic [NUM_PORTS-1:0]                   rd_req, wr_req;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   rd_word_p0;
  logic [NUM_PORTS-1:0]                   vld_p1;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   rd_data_p1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(WORDS - 1)) state_d = READY;
      end
      READY: ;
      default: state_d = INIT;
    endcase
  end

  assign OUT_busy = (state_q == INIT);

  // Requests are only honoured once the sweep has finished.
  assign rd_req = (state_q == READY) ? (~IN_ce &  IN_we) : '0;
  assign wr_req = (state_q == READY) ? (~IN_ce & ~IN_we) : '0;

  // Stage p0: array lookup, optionally patched with this cycle's writes
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_word_p0[p] = mem[IN_addr[p]];
`ifdef CACHE_BANK_SRAM_FWD_EN
      for (int q = 0; q < NUM_PORTS; q++) begin
        for (int b = 0; b < NB; b++) begin
          if (wr_req[q] && IN_wm[q][b] && (IN_addr[q] == IN_addr[p]))
            rd_word_p0[p][b*8 +: 8] = IN_data[q][b*8 +: 8];
        end
      end
`endif
    end
  end

  // Ascending port order lets the highest-numbered port win each byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q == INIT) begin
        mem[cnt_q] <= '0;
      end else begin
        for (int q = 0; q < NUM_PORTS; q++) begin
          for (int b = 0; b < NB; b++) begin
            if (wr_req[q] && IN_wm[q][b])
              mem[IN_addr[q]][b*8 +: 8] <= IN_data[q][b*8 +: 8];
          end
        end
      end
    end
  end

  // Stage p1: registered array read
  always_ff @(posedge clk) begin
    if (!rst) vld_p1 <= '0;
    else      vld_p1 <= rd_req;
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rd_req[p]) rd_data_p1[p] <= rd_word_p0[p];
    end
  end

  // Stage p2: output register, holds until the port reads again
  always_ff @(posedge clk) begin
    if (!rst) begin
      OUT_data <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (vld_p1[p]) OUT_data[p] <= rd_data_p1[p];
      end
    end
  end

endmodule

// File: tb/tb_cache_bank_sram.sv
// Bench for cache_bank_sram: directed vector table, reset sequences and a randomized
// phase checked every cycle against a word-array reference model.
module tb_cache_bank_sram;
  localparam int NP = 2;
  localparam int DW = 32;
  localparam int WORDS = 256;
  localparam int IW = 8;
`ifdef CACHE_BANK_SRAM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0]          IN_ce, IN_we;
  logic [NP-1:0][3:0]     IN_wm;
  logic [NP-1:0][IW-1:0]  IN_addr;
  logic [NP-1:0][DW-1:0]  IN_data;
  logic [NP-1:0][DW-1:0]  OUT_data;
  logic                   OUT_busy;

  cache_bank_sram #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .IN_ce(IN_ce), .IN_we(IN_we), .IN_wm(IN_wm),
    .IN_addr(IN_addr), .IN_data(IN_data), .OUT_data(OUT_data), .OUT_busy(OUT_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { longint due; int port; logic [31:0] val; } pend_t;
  logic [31:0] ref_mem [WORDS];
  logic [31:0] exp_out [NP];
  pend_t       pq[$];
  int          init_left = 0;
  int          next_idx = 0;
  bit          model_on = 1'b0;
  longint      cyc = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] wm);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (wm[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    logic [31:0] v;
    cyc++;
    if (!rst) begin
      model_on = 1'b1;
      init_left = WORDS;
      next_idx = 0;
      pq.delete();
      for (int p = 0; p < NP; p++) exp_out[p] = '0;
    end else begin
      for (int i = pq.size() - 1; i >= 0; i--)
        if (pq[i].due == cyc) begin
          exp_out[pq[i].port] = pq[i].val;
          pq.delete(i);
        end
      if (init_left > 0) begin
        ref_mem[next_idx] = '0;
        next_idx++;
        init_left--;
      end else begin
        for (int p = 0; p < NP; p++)
          if (!IN_ce[p] && IN_we[p]) begin
            v = ref_mem[IN_addr[p]];
            if (FWD)
              for (int q = 0; q < NP; q++)
                if (!IN_ce[q] && !IN_we[q] && IN_addr[q] == IN_addr[p])
                  v = merge(v, IN_data[q], IN_wm[q]);
            pq.push_back('{cyc + 1, p, v});
          end
        for (int q = 0; q < NP; q++)
          if (!IN_ce[q] && !IN_we[q])
            ref_mem[IN_addr[q]] = merge(ref_mem[IN_addr[q]], IN_data[q], IN_wm[q]);
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("model_busy", 32'(OUT_busy), 32'(init_left > 0));
      for (int p = 0; p < NP; p++)
        chk($sformatf("model_out%0d", p), OUT_data[p], exp_out[p]);
    end
  end

  // ---------------- stimulus helpers ----------------
  // op: 0 idle, 1 read, 2 write, 3 write-enable without chip-enable (must be ignored)
  typedef struct {
    int op; logic [7:0] addr; logic [31:0] data; logic [3:0] wm;
    bit chk_en; logic [31:0] exp;
  } pvec_t;
  typedef struct { pvec_t p0; pvec_t p1; } vec_t;

  function automatic pvec_t mk(input int op, input logic [7:0] addr, input logic [31:0] data,
                               input logic [3:0] wm, input bit c, input logic [31:0] e);
    pvec_t r;
    r.op = op; r.addr = addr; r.data = data; r.wm = wm; r.chk_en = c; r.exp = e;
    return r;
  endfunction

  function automatic pvec_t idl();
    return mk(0, 8'd0, 32'd0, 4'd0, 1'b0, 32'd0);
  endfunction

  task automatic drive(input int p, input int op, input logic [7:0] addr,
                       input logic [31:0] data, input logic [3:0] wm);
    IN_ce[p]   = !(op == 1 || op == 2);
    IN_we[p]   = !(op == 2 || op == 3);
    IN_addr[p] = addr;
    IN_data[p] = data;
    IN_wm[p]   = wm;
  endtask

  task automatic idle_all();
    for (int p = 0; p < NP; p++) drive(p, 0, 8'd0, 32'd0, 4'd0);
  endtask

  task automatic count_busy(input string name);
    int n = 0;
    for (int i = 0; i < 400; i++) begin
      if (!OUT_busy) break;
      n++;
      @(negedge clk);
    end
    chk(name, n, WORDS);
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b0;
    idle_all();
    repeat (3) @(negedge clk);
    chk("reset_out0", OUT_data[0], 32'd0);
    chk("reset_out1", OUT_data[1], 32'd0);
    chk("reset_busy", 32'(OUT_busy), 32'd1);

    rst = 1'b1;
    count_busy("init_busy_cycles");

    drive(0, 1, 8'($urandom_range(0, 255)), 32'd0, 4'd0);
    drive(1, 1, 8'd255, 32'd0, 4'd0);
    @(negedge clk);
    idle_all();
    @(negedge clk);
    chk("init_zero_p0", OUT_data[0], 32'd0);
    chk("init_zero_p1", OUT_data[1], 32'd0);

    tbl.push_back('{mk(2, 5, 32'hDEADBEEF, 4'hF, 0, 0), idl()});
    tbl.push_back('{idl(), mk(1, 5, 0, 0, 0, 0)});
    tbl.push_back('{idl(), mk(0, 0, 0, 0, 1, 32'hDEADBEEF)});
    tbl.push_back('{mk(2, 7, 32'h11223344, 4'hF, 0, 0), idl()});
    tbl.push_back('{mk(2, 7, 32'hAABBCCDD, 4'h3, 0, 0), mk(2, 7, 32'h55667788, 4'h6, 0, 0)});
    tbl.push_back('{mk(1, 7, 0, 0, 0, 0), idl()});
    tbl.push_back('{mk(0, 0, 0, 0, 1, 32'h116677DD), idl()});
    tbl.push_back('{mk(2, 9, 32'hFFFFFFFF, 4'h1, 0, 0), mk(1, 9, 0, 0, 0, 0)});
    tbl.push_back('{mk(0, 0, 0, 0, 1, 32'h116677DD),
                    mk(0, 0, 0, 0, 1, FWD ? 32'h000000FF : 32'h00000000)});
    tbl.push_back('{idl(), mk(1, 9, 0, 0, 0, 0)});
    tbl.push_back('{mk(1, 5, 0, 0, 0, 0), mk(1, 5, 0, 0, 1, 32'h000000FF)});
    tbl.push_back('{mk(0, 0, 0, 0, 1, 32'hDEADBEEF), mk(0, 0, 0, 0, 1, 32'hDEADBEEF)});
    tbl.push_back('{mk(3, 5, 32'h0, 4'hF, 0, 0), idl()});
    tbl.push_back('{mk(1, 5, 0, 0, 0, 0), idl()});
    tbl.push_back('{mk(0, 0, 0, 0, 1, 32'hDEADBEEF), idl()});

    for (int i = 0; i < tbl.size(); i++) begin
      drive(0, tbl[i].p0.op, tbl[i].p0.addr, tbl[i].p0.data, tbl[i].p0.wm);
      drive(1, tbl[i].p1.op, tbl[i].p1.addr, tbl[i].p1.data, tbl[i].p1.wm);
      @(negedge clk);
      if (tbl[i].p0.chk_en) chk($sformatf("vec%0d_p0", i), OUT_data[0], tbl[i].p0.exp);
      if (tbl[i].p1.chk_en) chk($sformatf("vec%0d_p1", i), OUT_data[1], tbl[i].p1.exp);
    end

    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < NP; p++)
        drive(p, int'($urandom_range(0, 3)), 8'($urandom_range(0, 7)), $urandom,
              4'($urandom_range(0, 15)));
      @(negedge clk);
    end
    idle_all();
    repeat (3) @(negedge clk);

    // Reset with reads in flight: none of them may reach OUT_data.
    drive(0, 2, 8'd3, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    drive(0, 1, 8'd3, 0, 0); drive(1, 1, 8'd3, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle_all();
    chk("midrst_out0", OUT_data[0], 32'd0);
    chk("midrst_out1", OUT_data[1], 32'd0);
    chk("midrst_busy", 32'(OUT_busy), 32'd1);
    count_busy("midrst_busy_cycles");
    drive(0, 1, 8'd3, 0, 0); drive(1, 1, 8'd7, 0, 0);
    @(negedge clk);
    idle_all();
    @(negedge clk);
    chk("midrst_cleared_idx3", OUT_data[0], 32'd0);
    chk("midrst_cleared_idx7", OUT_data[1], 32'd0);

    // Reset partway through the sweep restarts it from index 0.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    count_busy("initrst_busy_cycles");
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
